// File: rtl/fetch_pkg.sv
// Shared types and sizing helpers for the instruction prefetch queue.
// Imported by the queue, its pointer sub-module and the bus interface.
package fetch_pkg;

    localparam int INSTR_W = 32;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'd0;

    // One queued fetch result: the incremented PC travels with its instruction.
    typedef struct packed {
        logic [31:0]        pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    // Pointer width for a given depth; never narrower than one bit.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Bus between fetch/decode (master) and the prefetch queue (slave).
// Carries the push side, the pop controls and the queue status.
interface fetch_queue_if #(
    parameter int DEPTH = 4
) ();
    import fetch_pkg::*;

    localparam int CNT_W = ptr_width(DEPTH) + 1;

    logic                 in_valid;
    logic [31:0]          in_pc;
    logic [INSTR_W-1:0]   in_instr;
    logic                 flush;
    logic                 freeze;

    logic                 full;
    logic                 out_valid;
    logic [31:0]          out_pc;
    logic [INSTR_W-1:0]   out_instr;
    logic [CNT_W-1:0]     count;
    logic                 overflow;

    modport master (
        output in_valid, in_pc, in_instr, flush, freeze,
        input  full, out_valid, out_pc, out_instr, count, overflow
    );

    modport slave (
        input  in_valid, in_pc, in_instr, flush, freeze,
        output full, out_valid, out_pc, out_instr, count, overflow
    );

endinterface

// File: rtl/fetch_queue_pointer.sv
// Wrapping pointer with increment enable and synchronous clear.
// Used for both the write and the read side of the prefetch queue.
module queue_pointer #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] value
);

    localparam logic [WIDTH-1:0] STEP = WIDTH'(1);

    // Clear beats increment so a flush always lands the pointer at zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value <= '0;
        end else if (clear) begin
            value <= '0;
        end else if (inc) begin
            value <= value + STEP;
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// Prefetch queue between instruction fetch and decode, with branch flush.
// Head is read combinationally; a push is only visible after its clock edge.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    fetch_queue_if.slave q
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic             overflow_q;
    entry_t           mem [DEPTH];
    entry_t           head;

    logic             is_full;
    logic             is_valid;
    logic             push;
    logic             pop;

    // Full looks only at the registered count, keeping full -> freeze loop-free.
    assign is_full  = (count_q == FULL_COUNT);
    assign is_valid = (count_q != '0);
    assign push     = q.in_valid & ~is_full & ~q.flush;
    assign pop      = is_valid & ~q.freeze & ~q.flush;

    queue_pointer #(
        .WIDTH (PTR_W)
    ) u_wr_ptr (
        .clk   (clk),
        .rst   (rst),
        .clear (q.flush),
        .inc   (push),
        .value (wr_ptr)
    );

    queue_pointer #(
        .WIDTH (PTR_W)
    ) u_rd_ptr (
        .clk   (clk),
        .rst   (rst),
        .clear (q.flush),
        .inc   (pop),
        .value (rd_ptr)
    );

    // Entry storage; a flush leaves stale data in place since count hides it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr] <= '{pc: q.in_pc, instr: q.in_instr};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else if (q.flush) begin
            count_q <= '0;
        end else begin
            case ({push, pop})
                2'b10:   count_q <= count_q + ONE;
                2'b01:   count_q <= count_q - ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    // Sticky: fetch ignored full, which is a fetch-side bug worth latching.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow_q <= 1'b0;
        end else if (q.in_valid & is_full & ~q.flush) begin
            overflow_q <= 1'b1;
        end
    end

    assign head        = mem[rd_ptr];
    assign q.full      = is_full;
    assign q.out_valid = is_valid;
    assign q.out_pc    = is_valid ? head.pc    : 32'd0;
    assign q.out_instr = is_valid ? head.instr : NOP_INSTR;
    assign q.count     = count_q;
    assign q.overflow  = overflow_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: fill/drain, overflow, streaming wrap,
// flush and asynchronous reset, all against hand-computed values.
module tb_fetch_queue;
    import fetch_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    int   tests_run    = 0;
    int   tests_failed = 0;

    fetch_queue_if #(.DEPTH(DEPTH)) bus ();

    fetch_queue #(
        .DEPTH (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .q   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return 32'hE1A0_0000 | pc;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [31:0] pc,
                                 input logic [31:0] instr, input logic fl,
                                 input logic fz);
        bus.in_valid = valid;
        bus.in_pc    = pc;
        bus.in_instr = instr;
        bus.flush    = fl;
        bus.freeze   = fz;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        tick();
        tick();
        checkOutput("reset_count",     32'(bus.count),     32'd0);
        checkOutput("reset_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("reset_full",      32'(bus.full),      32'd0);
        checkOutput("reset_overflow",  32'(bus.overflow),  32'd0);
        rst = 1'b1;

        // Fill with decode frozen
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b1, 32'(4 * i), instr_of(32'(4 * i)), 1'b0, 1'b1);
            tick();
            checkOutput($sformatf("fill_count_%0d", i), 32'(bus.count), 32'(i));
        end
        checkOutput("fill_full",      32'(bus.full),     32'd1);
        checkOutput("fill_head_pc",   bus.out_pc,        32'd4);
        checkOutput("fill_head_inst", bus.out_instr,     instr_of(32'd4));
        checkOutput("fill_no_ovf",    32'(bus.overflow), 32'd0);

        // Push while full and frozen
        applyStimulus(1'b1, 32'd20, instr_of(32'd20), 1'b0, 1'b1);
        tick();
        checkOutput("ovf_set",   32'(bus.overflow), 32'd1);
        checkOutput("ovf_count", 32'(bus.count),    32'd4);
        checkOutput("ovf_head",  bus.out_pc,        32'd4);

        // Unfreeze with in_valid held: pop happens, push refused
        applyStimulus(1'b1, 32'd20, instr_of(32'd20), 1'b0, 1'b0);
        tick();
        checkOutput("pop_full_count", 32'(bus.count), 32'd3);
        checkOutput("pop_full_pc",    bus.out_pc,     32'd8);
        checkOutput("pop_full_flag",  32'(bus.full),  32'd0);

        applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            tick();
            checkOutput($sformatf("drain_count_%0d", k), 32'(bus.count), 32'(2 - k));
            checkOutput($sformatf("drain_pc_%0d", k),    bus.out_pc,     32'(12 + 4 * k));
            checkOutput($sformatf("drain_inst_%0d", k),  bus.out_instr,  instr_of(32'(12 + 4 * k)));
        end
        tick();
        checkOutput("drained_count", 32'(bus.count),     32'd0);
        checkOutput("drained_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("drained_pc",    bus.out_pc,         32'd0);
        checkOutput("drained_inst",  bus.out_instr,      32'd0);
        checkOutput("ovf_after_drain", 32'(bus.overflow), 32'd1);

        applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        tick();
        checkOutput("ovf_after_flush", 32'(bus.overflow), 32'd1);

        // Streaming through two pointer wraps
        for (int i = 1; i <= 10; i++) begin
            applyStimulus(1'b1, 32'(4 * i), instr_of(32'(4 * i)), 1'b0, 1'b0);
            tick();
            checkOutput($sformatf("stream_count_%0d", i), 32'(bus.count), 32'd1);
            checkOutput($sformatf("stream_pc_%0d", i),    bus.out_pc,     32'(4 * i));
        end
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        tick();
        checkOutput("stream_end_count", 32'(bus.count), 32'd0);

        // Flush with a simultaneous push
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 32'(32'h40 + 4 * i), instr_of(32'(32'h40 + 4 * i)), 1'b0, 1'b1);
            tick();
        end
        checkOutput("preflush_count", 32'(bus.count), 32'd3);
        applyStimulus(1'b1, 32'h100, instr_of(32'h100), 1'b1, 1'b1);
        tick();
        checkOutput("flush_count", 32'(bus.count),     32'd0);
        checkOutput("flush_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("flush_inst",  bus.out_instr,      32'd0);
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        tick();
        checkOutput("flush_drop", 32'(bus.out_valid), 32'd0);
        applyStimulus(1'b1, 32'h200, instr_of(32'h200), 1'b0, 1'b1);
        tick();
        checkOutput("postflush_pc",   bus.out_pc,     32'h200);
        checkOutput("postflush_inst", bus.out_instr,  instr_of(32'h200));
        checkOutput("postflush_cnt",  32'(bus.count), 32'd1);

        // Asynchronous reset mid-stream with count = 3 and overflow set
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 32'(32'h300 + 4 * i), instr_of(32'(32'h300 + 4 * i)), 1'b0, 1'b1);
            tick();
        end
        checkOutput("prerst_count", 32'(bus.count), 32'd3);
        rst = 1'b0;
        #1;
        checkOutput("arst_count", 32'(bus.count),     32'd0);
        checkOutput("arst_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("arst_pc",    bus.out_pc,         32'd0);
        checkOutput("arst_inst",  bus.out_instr,      32'd0);
        checkOutput("arst_full",  32'(bus.full),      32'd0);
        checkOutput("arst_ovf",   32'(bus.overflow),  32'd0);
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        tick();
        rst = 1'b1;

        applyStimulus(1'b1, 32'd4, 32'hE3A0_0001, 1'b0, 1'b1);
        #1;
        checkOutput("no_fallthrough", 32'(bus.out_valid), 32'd0);
        tick();
        checkOutput("first_push_pc",   bus.out_pc,     32'd4);
        checkOutput("first_push_inst", bus.out_instr,  32'hE3A0_0001);
        checkOutput("first_push_cnt",  32'(bus.count), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
